lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
  ADDR_W, 32, byte-address width.
  MISALIGN_EN, 1, 1 = split misaligned accesses into two beats; 0 = reject them with an error.
  TIMEOUT_CYC, 16, maximum cycles to wait for mem_ack per beat; 0 disables the timeout.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
  clk  input  1  clock, rising edge.
  rst  input  1  reset, asynchronous, active-low.
  req_valid  input  1  access request.
  req_ready  output  1  high = request accepted this cycle.
  req_load  input  1  load access.
  req_store  input  1  store access.
  req_addr  input  ADDR_W  byte address.
  req_wdata  input  32  store data, LSB-aligned.
  req_fun3  input  3  RV32I funct3.
  rsp_valid  output  1  one-cycle completion pulse.
  rsp_rdata  output  32  extended load data.
  rsp_err  output  1  error flag, qualified by rsp_valid.
  mem_req  output  1  bus beat request.
  mem_we  output  1  write beat.
  mem_addr  output  ADDR_W  word-aligned beat address.
  mem_mask  output  4  byte enables.
  mem_wdata  output  32  lane-shifted write data.
  mem_ack  input  1  beat complete; rdata valid in the same cycle.
  mem_rdata  input  32  read word.
REQ-003 Clock SHALL be clk; reset SHALL be rst, asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, BEAT0, BEAT1 and RESP; req_ready SHALL equal (state == IDLE).
REQ-005 A request SHALL be accepted on req_valid & req_ready. The block SHALL latch addr, wdata, fun3 and load/store. If both req_load and req_store are 0 the request SHALL be ignored. If both are 1, load SHALL win.
REQ-006 Legal fun3 values:
  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  store: 000 SB, 001 SH, 010 SW.
  Any other value SHALL go IDLE->RESP with no bus beat, rsp_err=1, rsp_rdata=0.
REQ-007 Let k = addr[1:0] and size = 1, 2 or 4 bytes. The access is misaligned if k+size > 4.
REQ-008 Aligned access: IDLE->BEAT0, then mask = ((1<<size)-1)<<k, mem_addr = {addr[ADDR_W-1:2], 2'b00}, mem_wdata = wdata<<(8k).
REQ-009 Misaligned access with MISALIGN_EN=1:
  BEAT0 mask = (4'hF<<k) restricted to the access bytes; BEAT0 address is the base word.
  BEAT1 address = base+4 (wraps modulo 2^ADDR_W); BEAT1 mask = remaining low bytes; BEAT1 data = wdata>>(8(4-k)).
REQ-010 Misaligned access with MISALIGN_EN=0: IDLE->RESP with rsp_err=1 and no bus beat.
REQ-011 mem_req, mem_we, mem_addr, mem_mask and mem_wdata SHALL be registered and held stable from entry to BEATx until the mem_ack cycle. mem_req SHALL drop in the cycle after ack unless the next beat follows immediately.
REQ-012 On ack in BEAT0, go to BEAT1 if split, else RESP; on ack in BEAT1, go to RESP. For a load, each beat's mem_rdata SHALL be captured in its ack cycle.
REQ-013 Loads SHALL assemble (r0>>8k)|(r1<<8(4-k)), take the low size bytes, then sign-extend for LB/LH or zero-extend for LBU/LHU/LW.
REQ-014 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE. rsp_rdata SHALL be 0 for stores and for errors.
REQ-015 Latency: aligned access with ack in the first BEAT0 cycle gives rsp_valid 2 cycles after acceptance; a split access adds 1 cycle per beat.
REQ-016 A per-beat counter SHALL clear on BEATx entry. When TIMEOUT_CYC≠0 and the count reaches TIMEOUT_CYC without ack:
  mem_req drops, state goes to RESP with rsp_err=1, rsp_rdata=0.
  A write already acked in BEAT0 is not rolled back.
REQ-017 An ack arriving in the same cycle as the timeout SHALL count as success.
REQ-018 mem_ack seen outside BEATx SHALL be ignored.

Reset
REQ-019 While rst=0, outputs SHALL asynchronously go to: state IDLE, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_mask=0, mem_wdata=0, timeout counter 0.
REQ-020 req_ready SHALL rise in the first clk edge after rst deasserts.
REQ-021 An access in flight at reset SHALL be abandoned with no response.

Verification
REQ-022 SW addr 0x100, wdata 0xDEADBEEF, ack next cycle -> mem_addr 0x100, mask 1111, wdata 0xDEADBEEF, rsp_valid 2 cycles after accept, rsp_err 0.
REQ-023 LB addr 0x103 with rdata 0x80xxxxxx -> mask 1000, rsp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-024 LW addr 0x101 with MISALIGN_EN=1, r0=0x44332211, r1=0x88776655 -> beats 0x100/1110 then 0x104/0001, rsp_rdata 0x55443322.
REQ-025 SH addr 0x203 with MISALIGN_EN=0 -> no mem_req, rsp_err=1 the cycle after accept; fun3=011 load -> same error.
REQ-026 TIMEOUT_CYC=4 with ack held low -> mem_req drops after 4 cycles, rsp_err=1; ack coincident with the 4th cycle -> success.
REQ-027 rst pulsed low mid-BEAT1 -> mem_req=0 immediately, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- RV32I load/store unit controller.
//
// Accepts one load or store at a time, drives one bus beat (or two when an
// access straddles a word boundary), assembles and extends load data, and
// reports completion with a one-cycle response pulse.
//
// Parameters
//   ADDR_W       byte-address width
//   MISALIGN_EN  1 = split word-crossing accesses into two beats, 0 = error
//   TIMEOUT_CYC  max cycles per beat waiting for mem_ack (0 = wait forever)
//
// Ports
//   clk, rst                       clock (rising edge), async active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_load/req_store             access kind (load wins if both set)
//   req_addr/req_wdata/req_fun3    byte address, LSB-aligned store data, funct3
//   rsp_valid/rsp_rdata/rsp_err    one-cycle completion, load data, error flag
//   mem_req/mem_we/mem_addr        registered beat request, write, word address
//   mem_mask/mem_wdata             byte enables and lane-shifted write data
//   mem_ack/mem_rdata              beat completion and read word (same cycle)
// -----------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_fun3,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_mask,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  localparam bit TIMEOUT_ON = (TIMEOUT_CYC != 0);
  localparam int CNT_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // The counter holds (cycles spent in the beat - 1); the last allowed cycle
  // is therefore TIMEOUT_CYC-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic fun3_ok(input logic ld, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (ld) begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        default:                                ok = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010: ok = 1'b1;
        default:                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic              alive_reg;
  logic              load_reg, load_next;
  logic              split_reg, split_next;
  logic [2:0]        fun3_reg, fun3_next;
  logic [1:0]        k_reg, k_next;
  logic [3:0]        b1_mask_reg, b1_mask_next;
  logic [31:0]       b1_wdata_reg, b1_wdata_next;
  logic [31:0]       r0_reg, r0_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [3:0]        mem_mask_reg, mem_mask_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic              rsp_err_reg, rsp_err_next;
  logic [31:0]       rsp_rdata_reg, rsp_rdata_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  // ---------------------------------------------------------------------------
  // Incoming request decode. Lanes and data are computed across two words;
  // the upper half is what spills into the second beat.
  // ---------------------------------------------------------------------------
  logic [7:0]  in_lanes;
  logic [63:0] in_data;
  logic        in_split;
  logic        in_legal;

  assign in_lanes = {4'd0, size_mask(req_fun3[1:0])} << req_addr[1:0];
  assign in_data  = {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
  assign in_split = |in_lanes[7:4];
  assign in_legal = fun3_ok(req_load, req_fun3);

  // ---------------------------------------------------------------------------
  // Load assembly: the access bytes start at lane k of the first word and
  // continue into the second word. For a single beat the current read word
  // serves as both halves; bytes from the "second word" are never selected.
  // ---------------------------------------------------------------------------
  logic [31:0] asm_lo;
  logic [31:0] asm_word;
  logic [31:0] load_result;

  assign asm_lo = split_reg ? r0_reg : mem_rdata;

  always_comb begin
    case (k_reg)
      2'd0:    asm_word = asm_lo;
      2'd1:    asm_word = {mem_rdata[7:0],  asm_lo[31:8]};
      2'd2:    asm_word = {mem_rdata[15:0], asm_lo[31:16]};
      default: asm_word = {mem_rdata[23:0], asm_lo[31:24]};
    endcase
  end

  // fun3[2] set means unsigned (LBU/LHU); LW ignores it.
  always_comb begin
    case (fun3_reg[1:0])
      2'b00:   load_result = {{24{asm_word[7]  & ~fun3_reg[2]}}, asm_word[7:0]};
      2'b01:   load_result = {{16{asm_word[15] & ~fun3_reg[2]}}, asm_word[15:0]};
      default: load_result = asm_word;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    load_next      = load_reg;
    split_next     = split_reg;
    fun3_next      = fun3_reg;
    k_next         = k_reg;
    b1_mask_next   = b1_mask_reg;
    b1_wdata_next  = b1_wdata_reg;
    r0_next        = r0_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_mask_next  = mem_mask_reg;
    mem_wdata_next = mem_wdata_reg;
    cnt_next       = cnt_reg;
    // Response registers are only loaded on the transition into RESP.
    rsp_err_next   = 1'b0;
    rsp_rdata_next = 32'd0;

    case (state_reg)
      IDLE: begin
        if (req_valid && req_ready && (req_load || req_store)) begin
          load_next     = req_load;
          fun3_next     = req_fun3;
          k_next        = req_addr[1:0];
          split_next    = in_split;
          b1_mask_next  = in_lanes[7:4];
          b1_wdata_next = in_data[63:32];
          if (!in_legal || (in_split && !MISALIGN_EN)) begin
            state_next   = RESP;
            rsp_err_next = 1'b1;
          end else begin
            state_next     = BEAT0;
            mem_req_next   = 1'b1;
            mem_we_next    = !req_load;
            mem_addr_next  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_mask_next  = in_lanes[3:0];
            mem_wdata_next = in_data[31:0];
            cnt_next       = '0;
          end
        end
      end

      BEAT0, BEAT1: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (mem_ack) begin
          if (state_reg == BEAT0 && split_reg) begin
            state_next     = BEAT1;
            r0_next        = mem_rdata;
            mem_addr_next  = mem_addr_reg + ADDR_W'(4);
            mem_mask_next  = b1_mask_reg;
            mem_wdata_next = b1_wdata_reg;
            cnt_next       = '0;
          end else begin
            state_next     = RESP;
            mem_req_next   = 1'b0;
            rsp_rdata_next = load_reg ? load_result : 32'd0;
          end
        end else if (TIMEOUT_ON && cnt_reg == CNT_LAST) begin
          state_next   = RESP;
          mem_req_next = 1'b0;
          rsp_err_next = 1'b1;
        end else if (TIMEOUT_ON) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      alive_reg     <= 1'b0;
      load_reg      <= 1'b0;
      split_reg     <= 1'b0;
      fun3_reg      <= 3'd0;
      k_reg         <= 2'd0;
      b1_mask_reg   <= 4'd0;
      b1_wdata_reg  <= 32'd0;
      r0_reg        <= 32'd0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_mask_reg  <= 4'd0;
      mem_wdata_reg <= 32'd0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= 32'd0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      alive_reg     <= 1'b1;
      load_reg      <= load_next;
      split_reg     <= split_next;
      fun3_reg      <= fun3_next;
      k_reg         <= k_next;
      b1_mask_reg   <= b1_mask_next;
      b1_wdata_reg  <= b1_wdata_next;
      r0_reg        <= r0_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_mask_reg  <= mem_mask_next;
      mem_wdata_reg <= mem_wdata_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
      cnt_reg       <= cnt_next;
    end
  end

  // alive_reg keeps req_ready low while in reset and raises it on the first
  // clock edge after release.
  assign req_ready = alive_reg && (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_mask  = mem_mask_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
//
// Two instances share one set of drivers: dut_a splits misaligned accesses,
// dut_b rejects them; "sel" steers request/ack to one of them and selects
// which outputs are observed. Both use a 4-cycle beat timeout.
// Expected beats, latency and load data come from a byte-by-byte model.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        req_valid, req_load, req_store;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_fun3;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        a_req_ready, a_rsp_valid, a_rsp_err, a_mem_req, a_mem_we;
  logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_mask;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_mem_req, b_mem_we;
  logic [31:0] b_rsp_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_mask;

  logic        req_ready, rsp_valid, rsp_err, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_mask;

  assign req_ready = sel ? b_req_ready : a_req_ready;
  assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign mem_req   = sel ? b_mem_req   : a_mem_req;
  assign mem_we    = sel ? b_mem_we    : a_mem_we;
  assign mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign mem_mask  = sel ? b_mem_mask  : a_mem_mask;
  assign mem_wdata = sel ? b_mem_wdata : a_mem_wdata;

  lsu_ctrl #(.ADDR_W(32), .MISALIGN_EN(1'b1), .TIMEOUT_CYC(4)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_load(req_load), .req_store(req_store), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_fun3(req_fun3),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_mask(a_mem_mask), .mem_wdata(a_mem_wdata),
    .mem_ack(mem_ack & ~sel), .mem_rdata(mem_rdata)
  );

  lsu_ctrl #(.ADDR_W(32), .MISALIGN_EN(1'b0), .TIMEOUT_CYC(4)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_load(req_load), .req_store(req_store), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_fun3(req_fun3),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_mask(b_mem_mask), .mem_wdata(b_mem_wdata),
    .mem_ack(mem_ack & sel), .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

  function automatic int rand_delay();
    int v;
    v = int'($urandom_range(0, 9));
    return (v <= 3) ? v : ((v == 9) ? 4 : 0);
  endfunction

  // One full transaction: model, drive, act as memory, check every cycle.
  // dN >= 4 means the bench never acks beat N (timeout).
  task automatic do_access(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int d0, input int d1,
                           input logic [31:0] r0, input logic [31:0] r1);
    logic [3:0]  emask [2];
    logic [31:0] edata [2];
    logic [31:0] rword [2];
    int          dly [2];
    int          dur [2];
    int          size, nb, np, lat, s, bb, beat, ln;
    bit          legal, err_cfg, tmo, last, mis_en;
    logic [31:0] a, val, exp_rd, exp_addr;

    rword[0] = r0; rword[1] = r1;
    dly[0] = d0;   dly[1] = d1;
    dur[0] = 0;    dur[1] = 0;
    emask[0] = 4'd0; emask[1] = 4'd0;
    edata[0] = 32'd0; edata[1] = 32'd0;
    mis_en = !sel;
    val = 32'd0;
    nb = 1;
    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      default: size = 4;
    endcase
    if (ld) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    else    legal = (f3 <= 3'd2);

    // Place every access byte into its word (beat) and lane.
    for (int i = 0; i < size; i++) begin
      a    = addr + 32'(i);
      beat = (a[31:2] != addr[31:2]) ? 1 : 0;
      ln   = int'(a[1:0]);
      emask[beat][ln] = 1'b1;
      edata[beat][ln*8 +: 8] = wd[i*8 +: 8];
      val[i*8 +: 8] = rword[beat][ln*8 +: 8];
      if (beat == 1) nb = 2;
    end
    exp_rd = val;
    if (size == 1 && !f3[2]) exp_rd = {{24{val[7]}}, val[7:0]};
    if (size == 2 && !f3[2]) exp_rd = {{16{val[15]}}, val[15:0]};

    err_cfg = !legal || (nb == 2 && !mis_en);
    np  = 0;
    tmo = 1'b0;
    if (!err_cfg) begin
      for (int b = 0; b < nb; b++) begin
        np++;
        dur[b] = (dly[b] >= 4) ? 4 : dly[b] + 1;
        if (dly[b] >= 4) begin
          tmo = 1'b1;
          break;
        end
      end
    end
    lat = 1;
    for (int b = 0; b < np; b++) lat += dur[b];
    if (err_cfg || tmo || !ld) exp_rd = 32'd0;

    @(negedge clk);
    check_eq("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_load = ld; req_store = st; req_fun3 = f3;
    req_addr = addr; req_wdata = wd; mem_ack = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    n_txn++;

    if (!(ld || st)) begin
      for (int c = 0; c < 3; c++) begin
        check_eq("ign_mem_req", 32'(mem_req), 32'd0);
        check_eq("ign_rsp", 32'(rsp_valid), 32'd0);
        check_eq("ign_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
      end
      $display("txn %0d sel=%0d ignored (no load/store)", n_txn, sel);
      return;
    end

    for (int c = 1; c <= lat; c++) begin
      bb = -1; last = 1'b0; s = 1;
      for (int b = 0; b < np; b++) begin
        if (c >= s && c < s + dur[b]) begin
          bb = b;
          last = (c == s + dur[b] - 1);
        end
        s += dur[b];
      end
      check_eq("mem_req", 32'(mem_req), 32'(bb >= 0));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(c == lat));
      if (bb >= 0) begin
        exp_addr = {addr[31:2], 2'b00} + ((bb == 1) ? 32'd4 : 32'd0);
        check_eq("mem_addr", mem_addr, exp_addr);
        check_eq("mem_mask", 32'(mem_mask), 32'(emask[bb]));
        check_eq("mem_we", 32'(mem_we), 32'(!ld));
        if (!ld) check_eq("mem_wdata", mem_wdata & lane_bits(emask[bb]), edata[bb]);
        mem_ack   = last && (dly[bb] < 4);
        mem_rdata = mem_ack ? rword[bb] : $urandom;
      end else begin
        // Stray acks outside a beat must be ignored.
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      if (c == lat) begin
        check_eq("rsp_err", 32'(rsp_err), 32'(err_cfg || tmo));
        check_eq("rsp_rdata", rsp_rdata, exp_rd);
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    check_eq("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    check_eq("ready_back", 32'(req_ready), 32'd1);
    check_eq("req_dropped", 32'(mem_req), 32'd0);
    $display("txn %0d sel=%0d ld=%0d st=%0d f3=%0d addr=%08h wd=%08h beats=%0d err=%0d rdata=%08h lat=%0d",
             n_txn, sel, ld, st, f3, addr, wd, np, err_cfg || tmo, exp_rd, lat);
  endtask

  initial begin
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] ad;
    int          r;

    rst = 1'b0; sel = 1'b0;
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; req_fun3 = 3'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;

    // Reset state
    #3;
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_mask", 32'(mem_mask), 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq("ready_after_edge", 32'(req_ready), 32'd1);

    // Directed cases on the splitting instance
    do_access(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0);
    do_access(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1, 0, 32'h8012_3456, 32'h0);
    do_access(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 0, 32'h8012_3456, 32'h0);
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 0, 32'h4433_2211, 32'h8877_6655);
    do_access(1'b0, 1'b1, 3'b001, 32'hFFFF_FFFF, 32'h1234_ABCD, 2, 1, 32'h0, 32'h0);
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 4, 0, 32'h1111_2222, 32'h0);
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 3, 0, 32'h1234_5678, 32'h0);
    do_access(1'b0, 1'b1, 3'b010, 32'h0000_0306, 32'hCAFE_F00D, 0, 4, 32'h0, 32'h0);
    do_access(1'b1, 1'b0, 3'b001, 32'h0000_0207, 32'h0, 2, 3, 32'h80AA_BBCC, 32'h0000_00F1);
    do_access(1'b1, 1'b1, 3'b101, 32'h0000_0102, 32'h5555_5555, 0, 0, 32'h9ABC_0000, 32'h0);
    do_access(1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 0, 32'h0, 32'h0);
    do_access(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 0, 32'h0, 32'h0);
    do_access(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h0, 0, 0, 32'h0, 32'h0);

    // Directed cases on the rejecting instance
    sel = 1'b1;
    do_access(1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0000_BEEF, 0, 0, 32'h0, 32'h0);
    do_access(1'b1, 1'b0, 3'b011, 32'h0000_0200, 32'h0, 0, 0, 32'h0, 32'h0);
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 0, 32'h4433_2211, 32'h8877_6655);
    do_access(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0, 1, 0, 32'hBEEF_0000, 32'h0);
    sel = 1'b0;

    // Reset in the middle of the second beat of a split load
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
    req_fun3 = 3'b010; req_addr = 32'h0000_0101;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("mr_beat0_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0102_0304;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("mr_beat1_req", 32'(mem_req), 32'd1);
    check_eq("mr_beat1_addr", mem_addr, 32'h0000_0104);
    #2 rst = 1'b0;
    #1;
    check_eq("mr_req_async", 32'(mem_req), 32'd0);
    check_eq("mr_rsp_async", 32'(rsp_valid), 32'd0);
    check_eq("mr_ready_async", 32'(req_ready), 32'd0);
    check_eq("mr_mask_async", 32'(mem_mask), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mr_ready_release", 32'(req_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("mr_no_rsp", 32'(rsp_valid), 32'd0);
      check_eq("mr_no_req", 32'(mem_req), 32'd0);
    end
    $display("txn reset mid-beat1 abandoned");

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      sel = (t % 5 == 4);
      r = int'($urandom_range(0, 15));
      if (r == 0)      begin ld = 1'b0; st = 1'b0; end
      else if (r == 1) begin ld = 1'b1; st = 1'b1; end
      else             begin ld = (r >= 9); st = !ld; end
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (ld)                   f3 = 3'($urandom_range(0, 4)) + ((r % 3 == 0) ? 3'd4 : 3'd0);
      else                           f3 = 3'($urandom_range(0, 2));
      ad = $urandom;
      if (t % 7 == 0) ad = {30'h3FFF_FFFF, ad[1:0]};
      do_access(ld, st, f3, ad, $urandom, rand_delay(), rand_delay(), $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
